// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Turns the PS/2 Set-2 byte stream from PS2_Controller into held key levels
//   for two players, plus sticky kick requests that persist until the slow
//   game tick consumes them.
//
// Ports
//   CLOCK_50          system clock (sole clock)
//   reset             synchronous, active-high
//   received_data     byte from PS2_Controller
//   received_data_en  one-cycle strobe qualifying received_data
//   game_tick         movement-rate pulse; consumes pending kick requests
//   p1_up/left/down/right   W/A/S/D held levels (opposing pairs cancel)
//   p2_up/left/down/right   arrow-key held levels (opposing pairs cancel)
//   p1_kick_req, p2_kick_req sticky requests for Space / Enter
//   proto_err         one-cycle pulse on prefix timeout or repeated F0
//
// Build option
//   PS2_TYPEMATIC_FILTER_EN : when defined, auto-repeat makes of Space/Enter
//   do not raise a new kick request; one physical press gives one kick.
module ps2_key_tracker #(
    parameter int PREFIX_TIMEOUT = 1000000,
    parameter int TO_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       game_tick,
    output logic       p1_up,
    output logic       p1_left,
    output logic       p1_down,
    output logic       p1_right,
    output logic       p2_up,
    output logic       p2_left,
    output logic       p2_down,
    output logic       p2_right,
    output logic       p1_kick_req,
    output logic       p2_kick_req,
    output logic       proto_err
);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    // Held-bit indices
    localparam int K_W     = 0;
    localparam int K_A     = 1;
    localparam int K_S     = 2;
    localparam int K_D     = 3;
    localparam int K_UP    = 4;
    localparam int K_LEFT  = 5;
    localparam int K_DOWN  = 6;
    localparam int K_RIGHT = 7;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(PREFIX_TIMEOUT);

    state_t          state, state_nxt;
    logic [7:0]      held, held_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      key_sel;
    logic [1:0]      kick_sel;    // [0]=Space, [1]=Enter
    logic            key_brk;     // current key code arrived with a break prefix
    logic            f0_err;
    logic            timeout;
    logic            is_ext, is_brk;
    logic [1:0]      kick_make, kick_set;
    logic [1:0]      req, req_nxt;

    assign is_ext = (state == EXT) || (state == EXT_BRK);
    assign is_brk = (state == BRK) || (state == EXT_BRK);

    // Next-state / decode
    always_comb begin
        state_nxt = state;
        key_sel   = '0;
        kick_sel  = '0;
        key_brk   = 1'b0;
        f0_err    = 1'b0;
        timeout   = 1'b0;
        if (received_data_en) begin
            if (received_data == 8'hE0) begin
                state_nxt = EXT;
            end else if (received_data == 8'hF0) begin
                case (state)
                    IDLE:    state_nxt = BRK;
                    EXT:     state_nxt = EXT_BRK;
                    default: f0_err    = 1'b1;   // F0 F0: stay, flag it
                endcase
            end else begin
                state_nxt = IDLE;
                key_brk   = is_brk;
                if (is_ext) begin
                    case (received_data)
                        8'h75:   key_sel[K_UP]    = 1'b1;
                        8'h72:   key_sel[K_DOWN]  = 1'b1;
                        8'h6B:   key_sel[K_LEFT]  = 1'b1;
                        8'h74:   key_sel[K_RIGHT] = 1'b1;
                        default: ;
                    endcase
                end else begin
                    case (received_data)
                        8'h1D:   key_sel[K_W] = 1'b1;
                        8'h1C:   key_sel[K_A] = 1'b1;
                        8'h1B:   key_sel[K_S] = 1'b1;
                        8'h23:   key_sel[K_D] = 1'b1;
                        8'h29:   kick_sel[0]  = 1'b1;
                        8'h5A:   kick_sel[1]  = 1'b1;
                        default: ;
                    endcase
                end
            end
        end else if (state != IDLE && to_cnt == TO_MAX) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
        end
    end

    // Held levels are independent of the opposing-pair rule; cancellation is
    // applied only on the way out so releasing one key exposes the other.
    assign held_nxt  = key_brk ? (held & ~key_sel) : (held | key_sel);
    assign kick_make = key_brk ? 2'b00 : kick_sel;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [1:0] seen;
    logic [1:0] kick_brk;
    assign kick_brk = key_brk ? kick_sel : 2'b00;
    assign kick_set = kick_make & ~seen;

    always_ff @(posedge CLOCK_50) begin
        if (reset) seen <= '0;
        else       seen <= (seen | kick_make) & ~kick_brk;
    end
`else
    assign kick_set = kick_make;
`endif

    // A tick consumes the old request; a make in the same cycle re-arms it.
    assign req_nxt = (req & ~{2{game_tick}}) | kick_set;
    assign p1_kick_req = req[0];
    assign p2_kick_req = req[1];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            held      <= '0;
            req       <= '0;
            to_cnt    <= '0;
            proto_err <= 1'b0;
            p1_up     <= 1'b0;
            p1_left   <= 1'b0;
            p1_down   <= 1'b0;
            p1_right  <= 1'b0;
            p2_up     <= 1'b0;
            p2_left   <= 1'b0;
            p2_down   <= 1'b0;
            p2_right  <= 1'b0;
        end else begin
            state     <= state_nxt;
            held      <= held_nxt;
            req       <= req_nxt;
            proto_err <= f0_err | timeout;
            // Counter clears on any byte and while idle; saturates at the limit.
            if (received_data_en || state == IDLE)
                to_cnt <= '0;
            else if (to_cnt != TO_MAX)
                to_cnt <= to_cnt + TO_W'(1);
            // Outputs come from held_nxt to keep one cycle of latency.
            p1_up    <= held_nxt[K_W]     & ~held_nxt[K_S];
            p1_down  <= held_nxt[K_S]     & ~held_nxt[K_W];
            p1_left  <= held_nxt[K_A]     & ~held_nxt[K_D];
            p1_right <= held_nxt[K_D]     & ~held_nxt[K_A];
            p2_up    <= held_nxt[K_UP]    & ~held_nxt[K_DOWN];
            p2_down  <= held_nxt[K_DOWN]  & ~held_nxt[K_UP];
            p2_left  <= held_nxt[K_LEFT]  & ~held_nxt[K_RIGHT];
            p2_right <= held_nxt[K_RIGHT] & ~held_nxt[K_LEFT];
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker. Stimulus updates a key-level model
// and queues the expected outputs; a monitor compares on every strobe, tick
// or probe cycle.
module tb_ps2_key_tracker;

    localparam int P = 40;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       game_tick = 1'b0;
    logic       probe = 1'b0;
    logic       p1_up, p1_left, p1_down, p1_right;
    logic       p2_up, p2_left, p2_down, p2_right;
    logic       p1_kick_req, p2_kick_req, proto_err;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_key_tracker #(.PREFIX_TIMEOUT(P), .TO_W(20)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .received_data(received_data), .received_data_en(received_data_en),
        .game_tick(game_tick),
        .p1_up(p1_up), .p1_left(p1_left), .p1_down(p1_down), .p1_right(p1_right),
        .p2_up(p2_up), .p2_left(p2_left), .p2_down(p2_down), .p2_right(p2_right),
        .p1_kick_req(p1_kick_req), .p2_kick_req(p2_kick_req), .proto_err(proto_err)
    );

    logic [10:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int perr_pulses = 0;

    // Reference model: which keys are physically down, pending prefixes,
    // and outstanding kick requests.
    bit       m_ext, m_brk;
    bit [7:0] m_down;   // W A S D Up Left Down Right
    bit [1:0] m_req, m_seen;

    // 0..7 movement keys, 8 Space, 9 Enter, -1 not a tracked key
    function automatic int key_of(bit ext, logic [7:0] c);
        if (ext) begin
            case (c)
                8'h75: return 4; 8'h6B: return 5; 8'h72: return 6; 8'h74: return 7;
                default: return -1;
            endcase
        end
        case (c)
            8'h1D: return 0; 8'h1C: return 1; 8'h1B: return 2; 8'h23: return 3;
            8'h29: return 8; 8'h5A: return 9;
            default: return -1;
        endcase
    endfunction

    function automatic logic [10:0] model_out(bit perr);
        bit w, a, s, d, u, l, dn, r;
        {r, dn, l, u, d, s, a, w} = m_down;
        return {perr, m_req[1], m_req[0],
                r & !l, dn & !u, l & !r, u & !dn,
                d & !a, s & !w, a & !d, w & !s};
    endfunction

    task automatic model_clear();
        m_ext = 0; m_brk = 0; m_down = '0; m_req = '0; m_seen = '0;
    endtask

    // Drive one cycle; queue the expected outputs for event cycles.
    task automatic cyc(input bit en, input logic [7:0] d, input bit tick, input bit prb);
        bit perr;
        bit [1:0] kset;
        int k;
        @(posedge CLOCK_50); #1;
        received_data_en = en; received_data = d; game_tick = tick; probe = prb;
        if (en || tick || prb) begin
            perr = 0; kset = '0;
            if (en) begin
                if (d == 8'hE0) begin
                    m_ext = 1; m_brk = 0;
                end else if (d == 8'hF0) begin
                    if (m_brk) perr = 1; else m_brk = 1;
                end else begin
                    k = key_of(m_ext, d);
                    if (k >= 0 && k < 8) m_down[k] = !m_brk;
                    else if (k >= 8) begin
                        if (m_brk) m_seen[k-8] = 0;
                        else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                            if (!m_seen[k-8]) kset[k-8] = 1;
`else
                            kset[k-8] = 1;
`endif
                            m_seen[k-8] = 1;
                        end
                    end
                    m_ext = 0; m_brk = 0;
                end
            end
            m_req = (m_req & ~{2{tick}}) | kset;
            exp_q.push_back(model_out(perr));
        end
    endtask

    task automatic send(input logic [7:0] b); cyc(1, b, 0, 0); endtask
    task automatic tick();                    cyc(0, 8'h00, 1, 0); endtask
    task automatic chk();                     cyc(0, 8'h00, 0, 1); endtask
    task automatic idle(input int n);
        repeat (n) cyc(0, 8'h00, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge CLOCK_50); #1;
        reset = 1; received_data_en = 0; game_tick = 0; probe = 0;
        repeat (2) @(posedge CLOCK_50);
        #1 reset = 0;
        model_clear();
    endtask

    // Monitor
    initial begin
        logic [10:0] e, act;
        forever begin
            @(posedge CLOCK_50);
            if (!reset && (received_data_en || game_tick || probe)) begin
                @(negedge CLOCK_50);
                act = {proto_err, p2_kick_req, p1_kick_req, p2_right, p2_down, p2_left, p2_up,
                       p1_right, p1_down, p1_left, p1_up};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow: got %b with nothing expected", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL outputs @%0t: got %b want %b", $time, act, e);
                    end
                end
            end
        end
    end

    always @(negedge CLOCK_50)
        if (!reset && proto_err === 1'b1) perr_pulses++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pool [13];
        int snap;
        pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A,
                 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'h12};
        model_clear();
        do_reset();
        chk();                                       // reset state

        // W make/break
        send(8'h1D); idle(2); send(8'hF0); send(8'h1D); chk();
        // Up make/break, then non-ext 75 (keypad 8)
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h75); chk();
        // A + D cancel, release A exposes D
        send(8'h1C); send(8'h23); chk(); send(8'hF0); send(8'h1C); chk();
        send(8'hF0); send(8'h23);
        // Repeated F0 pulses proto_err
        send(8'hF0); send(8'hF0); send(8'h23); chk();
        // Sticky Space request held for 10000 cycles, then consumed
        send(8'h29);
        repeat (10) begin idle(999); chk(); end
        tick(); chk();
        // Enter make in the same cycle as a tick
        send(8'h5A); cyc(1, 8'h5A, 1, 0); chk(); tick(); chk();
        send(8'hF0); send(8'h5A); send(8'hF0); send(8'h29);

        // Prefix timeout
        send(8'hE0);
        snap = perr_pulses;
        idle(P + 10);
        checks++;
        if (perr_pulses - snap != 1) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d want 1", perr_pulses - snap);
        end
        m_ext = 0; m_brk = 0;
        send(8'h75); chk();

        // Reset mid-prefix discards it
        send(8'hE0); do_reset(); send(8'h75); chk();

        // Typematic Space: 3 requests, or 1 with the filter
        send(8'h29); tick(); send(8'h29); tick(); send(8'h29); tick();
        send(8'hF0); send(8'h29); tick(); chk();

        // Random traffic (gaps stay well under the timeout)
        repeat (1500) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) cyc(1, pool[$urandom_range(0, 12)], ($urandom_range(0, 7) == 0), 0);
            else if (r < 8) tick();
            else if (r == 8) chk();
            else idle($urandom_range(1, 3));
        end

        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
